// File: rtl/note_sequencer.sv
// Plays 4-bit note codes from an internal four-song ROM, one beat-scaled note
// at a time with a silent gap after each, under start/pause/stop pulse control.
module note_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000,
  parameter int unsigned SONG_LEN    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [1:0] song_sel,
  input  logic       tempo_fast,
  output logic [3:0] key,
  output logic       key_on,
  output logic [4:0] note_index,
  output logic       playing,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam int unsigned MAX_CNT = (7 * BEAT_CYCLES > GAP_CYCLES) ? 7 * BEAT_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] BEAT_C   = CW'(BEAT_CYCLES);
  localparam logic [CW-1:0] GAP_C    = CW'(GAP_CYCLES);
  localparam logic [4:0]    LAST_IDX = 5'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_GAP   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Control pulses are single-cycle strobes with no back-pressure: each is
  // acted on in the cycle it is sampled, or dropped if the state ignores it.
  // Simultaneous pulses resolve stop, then pause, then start.

  // Entry layout {note[3:0], beats[2:0]}; beats == 0 ends the song.
  function automatic logic [6:0] rom_entry(input logic [1:0] song, input logic [4:0] idx);
    logic [6:0] e;
    case ({song, idx})
      {2'd0, 5'd0}: e = {4'd1,  3'd2};
      {2'd0, 5'd1}: e = {4'd3,  3'd2};
      {2'd0, 5'd2}: e = {4'd5,  3'd2};
      {2'd0, 5'd3}: e = {4'd6,  3'd2};
      {2'd0, 5'd4}: e = {4'd8,  3'd4};
      {2'd0, 5'd5}: e = {4'd0,  3'd1};
      {2'd0, 5'd6}: e = {4'd8,  3'd4};
      {2'd1, 5'd0}: e = {4'd5,  3'd1};
      {2'd1, 5'd1}: e = {4'd5,  3'd1};
      {2'd1, 5'd2}: e = {4'd6,  3'd2};
      {2'd1, 5'd3}: e = {4'd5,  3'd2};
      {2'd1, 5'd4}: e = {4'd8,  3'd2};
      {2'd1, 5'd5}: e = {4'd7,  3'd4};
      {2'd2, 5'd0}: e = {4'd10, 3'd3};
      {2'd2, 5'd1}: e = {4'd0,  3'd1};
      {2'd2, 5'd2}: e = {4'd12, 3'd1};
      {2'd2, 5'd3}: e = {4'd13, 3'd2};
      {2'd2, 5'd4}: e = {4'd15, 3'd7};
      {2'd3, 5'd0}: e = {4'd1,  3'd1};
      {2'd3, 5'd1}: e = {4'd2,  3'd1};
      {2'd3, 5'd2}: e = {4'd3,  3'd1};
      default:      e = 7'd0;
    endcase
    return e;
  endfunction

  state_t        state, nxt_state, ret_state, nxt_ret, adv_state;
  logic [CW-1:0] cnt, nxt_cnt, adv_cnt, dur_full, dur;
  logic [4:0]    nxt_idx, adv_idx;
  logic [1:0]    song_q, nxt_song;
  logic [3:0]    nxt_key;
  logic [6:0]    entry;

  assign state_dbg = state;

  always_comb begin
    entry    = rom_entry(song_q, note_index);
    dur_full = CW'(entry[2:0]) * BEAT_C;
    dur      = tempo_fast ? (dur_full >> 1) : dur_full;

    // Where PLAY/GAP would go this cycle absent any pulse; pause captures it.
    adv_state = state;
    adv_cnt   = cnt - CW'(1);
    adv_idx   = note_index;
    if (cnt <= CW'(1)) begin
      if (state == S_PLAY) begin
        adv_state = S_GAP;
        adv_cnt   = GAP_C;
      end else if (note_index == LAST_IDX) begin
        adv_state = S_DONE;
        adv_cnt   = '0;
      end else begin
        adv_state = S_LOAD;
        adv_cnt   = '0;
        adv_idx   = note_index + 5'd1;
      end
    end

    nxt_state = state;
    nxt_ret   = ret_state;
    nxt_cnt   = cnt;
    nxt_idx   = note_index;
    nxt_song  = song_q;
    nxt_key   = key;

    if (stop && state != S_IDLE) begin
      nxt_state = S_IDLE;
      nxt_cnt   = '0;
      nxt_idx   = '0;
      nxt_key   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            nxt_state = S_LOAD;
            nxt_song  = song_sel;
            nxt_idx   = '0;
            nxt_cnt   = '0;
          end
        end
        S_LOAD: begin
          if (entry[2:0] == 3'd0) begin
            nxt_state = S_DONE;
          end else begin
            nxt_state = S_PLAY;
            nxt_cnt   = dur;
            nxt_key   = entry[6:3];
          end
        end
        S_PLAY, S_GAP: begin
          nxt_cnt   = adv_cnt;
          nxt_idx   = adv_idx;
          if (pause) begin
            nxt_state = S_PAUSE;
            nxt_ret   = adv_state;
          end else begin
            nxt_state = adv_state;
          end
        end
        S_PAUSE: begin
          if (pause) nxt_state = ret_state;
        end
        S_DONE:  nxt_state = S_IDLE;
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ret_state  <= S_IDLE;
      cnt        <= '0;
      song_q     <= '0;
      key        <= '0;
      key_on     <= 1'b0;
      note_index <= '0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt_state;
      ret_state  <= nxt_ret;
      cnt        <= nxt_cnt;
      song_q     <= nxt_song;
      key        <= nxt_key;
      note_index <= nxt_idx;
      // Outputs are decoded from the state being entered so they line up with it.
      key_on     <= (nxt_state == S_PLAY) && (nxt_key != 4'd0);
      playing    <= (nxt_state == S_LOAD) || (nxt_state == S_PLAY) ||
                    (nxt_state == S_GAP)  || (nxt_state == S_PAUSE);
      done       <= (nxt_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer using the fixed test song 3 with
// short beats; per-cycle expected output vectors are queued and compared.
module tb_note_sequencer;

  localparam int BEAT = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] song_sel = 2'd0;
  logic       tempo_fast = 1'b0;
  logic [3:0] key;
  logic       key_on;
  logic [4:0] note_index;
  logic       playing;
  logic       done;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];
  logic [3:0]  mkey = 4'd0;

  note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .song_sel(song_sel), .tempo_fast(tempo_fast), .key(key), .key_on(key_on),
    .note_index(note_index), .playing(playing), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected vector layout: {done, playing, key_on, key[3:0], note_index[4:0]}.
  task automatic push_rep(input int n, input logic d, input logic p, input logic on,
                          input logic [3:0] k, input logic [4:0] idx);
    for (int j = 0; j < n; j++) exp_q.push_back({d, p, on, k, idx});
  endtask

  // Whole song 3 with no interruptions; dur = beat cycles per note.
  task automatic push_song_full(input int dur);
    for (int n = 0; n < 3; n++) begin
      push_rep(1, 0, 1, 0, mkey, 5'(n));
      mkey = 4'(n + 1);
      push_rep(dur, 0, 1, 1, mkey, 5'(n));
      push_rep(GAP, 0, 1, 0, mkey, 5'(n));
    end
    push_rep(1, 0, 1, 0, mkey, 5'd3);
    push_rep(1, 1, 0, 0, mkey, 5'd3);
    push_rep(1, 0, 0, 0, mkey, 5'd3);
  endtask

  // Drives one pulse schedule (tick numbers, 0 = never) while draining exp_q.
  task automatic run_trace(input string name, input int start_at, input int start_ignore,
                           input int pause_a, input int pause_b, input int stop_at,
                           input int rst_at, output int done_cycle);
    logic [11:0] exp_v, obs;
    int i;
    done_cycle = -1;
    i = 0;
    while (exp_q.size() > 0) begin
      i++;
      start    = (i == start_at) || (i == start_ignore);
      song_sel = (i == start_at) ? 2'd3 : 2'($urandom_range(0, 3));
      pause    = (i == pause_a) || (i == pause_b);
      stop     = (i == stop_at);
      rst      = (i == rst_at);
      tick();
      start = 1'b0; pause = 1'b0; stop = 1'b0; rst = 1'b0;
      exp_v = exp_q.pop_front();
      obs   = {done, playing, key_on, key, note_index};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got done=%0b playing=%0b key_on=%0b key=%0d idx=%0d, expected done=%0b playing=%0b key_on=%0b key=%0d idx=%0d",
                 name, i, obs[11], obs[10], obs[9], obs[8:5], obs[4:0],
                 exp_v[11], exp_v[10], exp_v[9], exp_v[8:5], exp_v[4:0]);
      end
      if (obs[11] === 1'b1 && done_cycle < 0) done_cycle = i;
    end
  endtask

  task automatic check_done_cycle(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks += 5;
    if (key !== 4'd0)        begin n_fail++; $display("FAIL reset key: got %0d, expected 0", key); end
    if (key_on !== 1'b0)     begin n_fail++; $display("FAIL reset key_on: got %0b, expected 0", key_on); end
    if (note_index !== 5'd0) begin n_fail++; $display("FAIL reset note_index: got %0d, expected 0", note_index); end
    if (playing !== 1'b0)    begin n_fail++; $display("FAIL reset playing: got %0b, expected 0", playing); end
    if (done !== 1'b0)       begin n_fail++; $display("FAIL reset done: got %0b, expected 0", done); end
    rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (playing !== 1'b0) begin n_fail++; $display("FAIL idle playing: got %0b, expected 0", playing); end
  endtask

  // Normal tempo; a stray start during PLAY must be ignored.
  task automatic test_song_normal();
    int dc;
    tempo_fast = 1'b0;
    push_song_full(BEAT);
    run_trace("song_normal", 1, 3, 0, 0, 0, 0, dc);
    check_done_cycle("song_normal", dc, 3 * (BEAT + GAP + 1) + 2);
  endtask

  task automatic test_song_fast();
    int dc;
    tempo_fast = 1'b1;
    push_song_full(BEAT / 2);
    run_trace("song_fast", 1, 7, 0, 0, 0, 0, dc);
    check_done_cycle("song_fast", dc, 3 * (2 + 2 + 1) + 1 + 1);
    tempo_fast = 1'b0;
  endtask

  // Pause after two high cycles of note 2, hold 10 cycles, then resume.
  task automatic test_pause();
    int dc;
    push_rep(1, 0, 1, 0, mkey, 5'd0);
    mkey = 4'd1;
    push_rep(BEAT, 0, 1, 1, 4'd1, 5'd0);
    push_rep(GAP, 0, 1, 0, 4'd1, 5'd0);
    push_rep(1, 0, 1, 0, 4'd1, 5'd1);
    mkey = 4'd2;
    push_rep(2, 0, 1, 1, 4'd2, 5'd1);
    push_rep(10, 0, 1, 0, 4'd2, 5'd1);
    push_rep(2, 0, 1, 1, 4'd2, 5'd1);
    push_rep(GAP, 0, 1, 0, 4'd2, 5'd1);
    push_rep(1, 0, 1, 0, 4'd2, 5'd2);
    mkey = 4'd3;
    push_rep(BEAT, 0, 1, 1, 4'd3, 5'd2);
    push_rep(GAP, 0, 1, 0, 4'd3, 5'd2);
    push_rep(1, 0, 1, 0, 4'd3, 5'd3);
    push_rep(1, 1, 0, 0, 4'd3, 5'd3);
    push_rep(1, 0, 0, 0, 4'd3, 5'd3);
    run_trace("pause", 1, 0, 11, 21, 0, 0, dc);
    check_done_cycle("pause", dc, 33);
  endtask

  // Stop and pause together in the first GAP cycle of note 1.
  task automatic test_stop_in_gap();
    int dc;
    push_rep(1, 0, 1, 0, mkey, 5'd0);
    mkey = 4'd1;
    push_rep(BEAT, 0, 1, 1, 4'd1, 5'd0);
    push_rep(1, 0, 1, 0, 4'd1, 5'd0);
    mkey = 4'd0;
    push_rep(4, 0, 0, 0, 4'd0, 5'd0);
    run_trace("stop_gap", 1, 0, 7, 0, 7, 0, dc);
    check_done_cycle("stop_gap", dc, -1);
  endtask

  // Reset in the middle of note 3, then a clean replay from entry 0.
  task automatic test_reset_mid_play();
    int dc;
    push_rep(1, 0, 1, 0, mkey, 5'd0);
    mkey = 4'd1;
    push_rep(BEAT, 0, 1, 1, 4'd1, 5'd0);
    push_rep(GAP, 0, 1, 0, 4'd1, 5'd0);
    push_rep(1, 0, 1, 0, 4'd1, 5'd1);
    mkey = 4'd2;
    push_rep(BEAT, 0, 1, 1, 4'd2, 5'd1);
    push_rep(GAP, 0, 1, 0, 4'd2, 5'd1);
    push_rep(1, 0, 1, 0, 4'd2, 5'd2);
    mkey = 4'd3;
    push_rep(2, 0, 1, 1, 4'd3, 5'd2);
    mkey = 4'd0;
    push_rep(3, 0, 0, 0, 4'd0, 5'd0);
    run_trace("reset_mid", 1, 0, 0, 0, 0, 18, dc);
    check_done_cycle("reset_mid", dc, -1);
    push_song_full(BEAT);
    run_trace("replay", 1, 0, 0, 0, 0, 0, dc);
    check_done_cycle("replay", dc, 3 * (BEAT + GAP + 1) + 2);
  endtask

  initial begin
    test_reset();
    test_song_normal();
    test_song_fast();
    test_pause();
    test_stop_in_gap();
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter BEAT_CYCLES, default 25_000_000: clock cycles per beat at normal tempo (0.25 s at 100 MHz).
REQ-002 Parameter GAP_CYCLES, default 2_500_000: silent cycles inserted after every note.
REQ-003 Parameter SONG_LEN, default 32: maximum entries per song.
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; begins playback of the selected song.
REQ-007 pause  input  1  one-cycle pulse; toggles between pause and resume.
REQ-008 stop  input  1  one-cycle pulse; aborts playback.
REQ-009 song_sel  input  2  song number; sampled only when start is accepted.
REQ-010 tempo_fast  input  1  1 = half-length beats; sampled at each LOAD.
REQ-011 key  output  4  note code (0..15) for the buzzer and LED datapath.
REQ-012 key_on  output  1  note sounding; drives buzzer key_on.
REQ-013 note_index  output  5  current song entry, feeds the 7-segment display.
REQ-014 playing  output  1  high in LOAD, PLAY, GAP and PAUSE.
REQ-015 done  output  1  one-cycle pulse when a song ends naturally.

Function
REQ-016 Internal ROM: 4 songs x SONG_LEN entries, 7 bits each: note[3:0], beats[2:0].
REQ-017 beats = 0 is the end marker; note = 0 is a rest.
REQ-018 Song 3 is the fixed test song: (1,1), (2,1), (3,1), end.
REQ-019 FSM states: IDLE, LOAD, PLAY, GAP, PAUSE, DONE.
REQ-020 IDLE: start -> LOAD next cycle; latch song_sel; note_index = 0.
REQ-021 LOAD (one cycle): read entry; end marker -> DONE.
REQ-022 LOAD, otherwise -> PLAY; duration = beats*BEAT_CYCLES, halved (floor) if tempo_fast = 1.
REQ-023 PLAY: key = entry note; key_on = 1 only if note != 0; count the duration exactly, then -> GAP.
REQ-024 GAP: key_on = 0; key holds its value; count GAP_CYCLES, then increment note_index and -> LOAD.
REQ-025 When GAP ends with note_index = SONG_LEN-1: -> DONE, no increment, no wrap.
REQ-026 DONE (one cycle): done = 1, playing = 0 -> IDLE; note_index holds its last value until the next start.
REQ-027 PLAY/GAP + pause: -> PAUSE; key_on = 0; counter frozen; return state stored.
REQ-028 PAUSE + pause: resume to the stored state with the remaining count intact.
REQ-029 pause in IDLE, LOAD or DONE is ignored.
REQ-030 stop in any non-IDLE state: -> IDLE next cycle; key = 0, key_on = 0, note_index = 0, no done pulse.
REQ-031 Priority on simultaneous pulses: stop > pause > start.
REQ-032 start outside IDLE is ignored; song_sel changes mid-song have no effect.
REQ-033 Latency: start sampled at edge t gives LOAD at t+1; key_on is high from t+2 (non-rest note).
REQ-034 Total note period = duration + GAP_CYCLES + 1 (LOAD) cycles.
REQ-035 Counters are wide enough for 7*BEAT_CYCLES without overflow.
REQ-036 All outputs are registered.

Reset
REQ-037 rst = 1 at a clock edge: state = IDLE, key = 0, key_on = 0, note_index = 0, playing = 0, done = 0, counters = 0, latched song = 0.
REQ-038 Reset applies from any state, including mid-note and PAUSE; rst has priority over every other input.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2, song 3)
REQ-039 start, song_sel=3 -> key_on high 4 cycles at key 1, 2 and 3, each followed by 2 low cycles.
REQ-040 (continuing REQ-039) note_index steps 0,1,2; done pulses once; playing drops with done.
REQ-041 tempo_fast=1 with same stimulus -> each note high 2 cycles; total 3*(2+2+1)+1+1 cycles from LOAD to DONE.
REQ-042 pause 2 cycles into note 2, hold 10 cycles, pause again -> key_on low 10 cycles, then exactly 2 more high cycles of key 2.
REQ-043 stop and pause in the same cycle during GAP -> IDLE next cycle, note_index 0, no done pulse.
REQ-044 rst asserted mid-PLAY of note 3 -> all outputs 0 next cycle; new start replays from note_index 0.
